// File: rtl/core_v_mcu_irq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_v_mcu_irq_pkg                                                   |
// | Interrupt controller register offsets, ID type and priority helper.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package core_v_mcu_irq_pkg;

  localparam int MaxIrqSrc = 32;

  localparam logic [31:0] IRQ_PENDING_OFFSET   = 32'h00;
  localparam logic [31:0] IRQ_ENABLE_OFFSET    = 32'h04;
  localparam logic [31:0] IRQ_MODE_OFFSET      = 32'h08;
  localparam logic [31:0] IRQ_CLAIM_OFFSET     = 32'h0C;
  localparam logic [31:0] IRQ_INSERVICE_OFFSET = 32'h10;

  typedef logic [5:0] irq_id_t;

  // Lowest set bit wins; returns 0 when the vector is empty.
  function automatic irq_id_t irq_lowest_id(input logic [MaxIrqSrc-1:0] vec);
    irq_id_t id;
    id = '0;
    for (int i = MaxIrqSrc - 1; i >= 0; i--) begin
      if (vec[i]) id = irq_id_t'(i + 1);
    end
    return id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_v_mcu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_v_mcu_pkg                                                       |
// | SoC-level constants: register-interface slave indices.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package core_v_mcu_pkg;

  localparam int NUM_REG_SLAVES = 6;
  localparam int IRQ_REG_IDX    = 5;

endpackage
`default_nettype wire

// File: rtl/core_v_mcu_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_v_mcu_reg_pkg                                                   |
// | Register-interface request/response types for bus slave ports.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package core_v_mcu_reg_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_resp_t;

endpackage
`default_nettype wire

// File: rtl/core_v_mcu_irq_gateway.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_v_mcu_irq_gateway                                               |
// | Per-source pending logic (edge/level); IRQ_CTRL_SYNC_EN adds 2FF sync.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module core_v_mcu_irq_gateway
  import core_v_mcu_irq_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  input  logic mode_i,
  input  logic claim_clr_i,
  input  logic w1c_i,
  input  logic mode_chg_i,
  output logic pending_o
);

  logic w_src_s;
  logic w_rise;
  logic r_src_q;
  logic r_pending;

`ifdef IRQ_CTRL_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], src_i};
    end
  end

  assign w_src_s = r_sync[1];
`else
  assign w_src_s = src_i;
`endif

  assign w_rise = w_src_s & ~r_src_q;

  // A fresh edge outranks a same-cycle clear so no event is ever lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_src_q   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_src_q <= w_src_s;
      if (mode_chg_i) begin
        r_pending <= 1'b0;
      end else if (!mode_i) begin
        r_pending <= w_src_s;
      end else if (w_rise) begin
        r_pending <= 1'b1;
      end else if (claim_clr_i || w1c_i) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign pending_o = r_pending;

endmodule
`default_nettype wire

// File: rtl/core_v_mcu_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_v_mcu_irq_ctrl                                                  |
// | Claim/complete interrupt aggregator; IRQ_CTRL_SYNC_EN syncs sources. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module core_v_mcu_irq_ctrl
  import core_v_mcu_irq_pkg::*;
#(
  parameter int NumSrc = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  core_v_mcu_reg_pkg::reg_req_t  reg_req_i,
  output core_v_mcu_reg_pkg::reg_resp_t reg_rsp_o,
  input  logic [NumSrc-1:0]             irq_src_i,
  output logic                          irq_o,
  output logic [5:0]                    claim_id_o
);

  logic [NumSrc-1:0] r_enable;
  logic [NumSrc-1:0] r_mode;
  logic [NumSrc-1:0] r_inservice;
  logic              r_irq;

  logic [NumSrc-1:0] w_pending;
  logic [NumSrc-1:0] w_claimable;
  logic [NumSrc-1:0] w_claim_oh;
  logic [NumSrc-1:0] w_complete_oh;
  logic [NumSrc-1:0] w_wmask;
  logic [NumSrc-1:0] w_enable_next;
  logic [NumSrc-1:0] w_mode_next;
  logic [NumSrc-1:0] w_mode_chg;
  logic [NumSrc-1:0] w_w1c;

  logic w_rd, w_wr, w_claim_fire, w_addr_ok;
  logic w_sel_pend, w_sel_en, w_sel_mode, w_sel_claim, w_sel_insvc;

  assign w_rd = reg_req_i.valid & ~reg_req_i.write;
  assign w_wr = reg_req_i.valid &  reg_req_i.write;

  assign w_sel_pend  = (reg_req_i.addr == IRQ_PENDING_OFFSET);
  assign w_sel_en    = (reg_req_i.addr == IRQ_ENABLE_OFFSET);
  assign w_sel_mode  = (reg_req_i.addr == IRQ_MODE_OFFSET);
  assign w_sel_claim = (reg_req_i.addr == IRQ_CLAIM_OFFSET);
  assign w_sel_insvc = (reg_req_i.addr == IRQ_INSERVICE_OFFSET);
  assign w_addr_ok   = w_sel_pend | w_sel_en | w_sel_mode | w_sel_claim | w_sel_insvc;

  assign w_claimable  = w_pending & r_enable & ~r_inservice;
  assign w_claim_oh   = w_claimable & (~w_claimable + NumSrc'(1));
  assign claim_id_o   = irq_lowest_id(32'(w_claimable));
  assign w_claim_fire = w_rd & w_sel_claim & (claim_id_o != '0);

  assign w_enable_next = (w_wr && w_sel_en)
                       ? ((r_enable & ~w_wmask) | (reg_req_i.wdata[NumSrc-1:0] & w_wmask))
                       : r_enable;
  assign w_mode_next   = (w_wr && w_sel_mode)
                       ? ((r_mode & ~w_wmask) | (reg_req_i.wdata[NumSrc-1:0] & w_wmask))
                       : r_mode;
  assign w_mode_chg    = w_mode_next ^ r_mode;
  assign w_w1c         = (w_wr && w_sel_pend && reg_req_i.wstrb[0])
                       ? reg_req_i.wdata[NumSrc-1:0] : '0;

  generate
    for (genvar i = 0; i < NumSrc; i++) begin : g_src
      assign w_wmask[i]       = reg_req_i.wstrb[i / 8];
      // The full data word is compared so out-of-range IDs never alias.
      assign w_complete_oh[i] = w_wr & w_sel_claim & reg_req_i.wstrb[0]
                              & (reg_req_i.wdata == 32'(i + 1));

      core_v_mcu_irq_gateway u_gateway (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .src_i       (irq_src_i[i]),
        .mode_i      (r_mode[i]),
        .claim_clr_i (w_claim_fire & w_claim_oh[i]),
        .w1c_i       (w_w1c[i]),
        .mode_chg_i  (w_mode_chg[i]),
        .pending_o   (w_pending[i])
      );
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_enable    <= '0;
      r_mode      <= '0;
      r_inservice <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_enable    <= w_enable_next;
      r_mode      <= w_mode_next;
      r_inservice <= (r_inservice | (w_claim_fire ? w_claim_oh : '0)) & ~w_complete_oh;
      r_irq       <= |w_claimable;
    end
  end

  assign irq_o = r_irq;

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = reg_req_i.valid;
    if (reg_req_i.valid) begin
      reg_rsp_o.error = ~w_addr_ok;
      if (w_rd) begin
        if (w_sel_pend)  reg_rsp_o.rdata = 32'(w_pending);
        if (w_sel_en)    reg_rsp_o.rdata = 32'(r_enable);
        if (w_sel_mode)  reg_rsp_o.rdata = 32'(r_mode);
        if (w_sel_claim) reg_rsp_o.rdata = 32'(claim_id_o);
        if (w_sel_insvc) reg_rsp_o.rdata = 32'(r_inservice);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_v_mcu_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_core_v_mcu_irq_ctrl                                               |
// | Directed + random bench with a per-source behavioural model.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_core_v_mcu_irq_ctrl;

  localparam int N = 8;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif
  localparam int LAT = 2 + SYNC_D;

  localparam logic [31:0] A_PEND  = 32'h00;
  localparam logic [31:0] A_EN    = 32'h04;
  localparam logic [31:0] A_MODE  = 32'h08;
  localparam logic [31:0] A_CLAIM = 32'h0C;
  localparam logic [31:0] A_INSVC = 32'h10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  core_v_mcu_reg_pkg::reg_req_t  req;
  core_v_mcu_reg_pkg::reg_resp_t rsp;
  logic [N-1:0] src;
  logic         irq;
  logic [5:0]   cid;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  core_v_mcu_irq_ctrl #(.NumSrc(N)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .reg_req_i  (req),
    .reg_rsp_o  (rsp),
    .irq_src_i  (src),
    .irq_o      (irq),
    .claim_id_o (cid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one bit per source in each array.
  logic [N-1:0] m_pend, m_en, m_mode, m_ins, m_q, m_s1, m_s2;
  logic         m_irq;

  function automatic int m_lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    case (a)
      A_PEND:  return 32'(m_pend);
      A_EN:    return 32'(m_en);
      A_MODE:  return 32'(m_mode);
      A_CLAIM: return 32'(m_lowest(m_pend & m_en & ~m_ins));
      A_INSVC: return 32'(m_ins);
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [N-1:0] s, cl, nen, nmode, npend, nins, wm;
    int c;
    logic rd, wr, claimed;
    if (rst) begin
      m_pend <= '0; m_en <= '0; m_mode <= '0; m_ins <= '0; m_q <= '0;
      m_irq  <= 1'b0;
      started <= 1'b1;
    end else begin
`ifdef IRQ_CTRL_SYNC_EN
      s = m_s2;
`else
      s = src;
`endif
      cl = m_pend & m_en & ~m_ins;
      c  = m_lowest(cl);
      rd = req.valid && !req.write;
      wr = req.valid && req.write;
      for (int i = 0; i < N; i++) wm[i] = req.wstrb[i / 8];
      nen = m_en;
      nmode = m_mode;
      if (wr && req.addr == A_EN)   nen   = (m_en   & ~wm) | (req.wdata[N-1:0] & wm);
      if (wr && req.addr == A_MODE) nmode = (m_mode & ~wm) | (req.wdata[N-1:0] & wm);
      claimed = rd && req.addr == A_CLAIM && c != 0;
      nins = m_ins;
      for (int i = 0; i < N; i++) begin
        if (nmode[i] != m_mode[i])      npend[i] = 1'b0;
        else if (!m_mode[i])            npend[i] = s[i];
        else if (s[i] && !m_q[i])       npend[i] = 1'b1;
        else if ((wr && req.addr == A_PEND && req.wstrb[0] && req.wdata[i]) ||
                 (claimed && c == i + 1)) npend[i] = 1'b0;
        else                            npend[i] = m_pend[i];
        if (claimed && c == i + 1) nins[i] = 1'b1;
        if (wr && req.addr == A_CLAIM && req.wstrb[0] && req.wdata == 32'(i + 1)) nins[i] = 1'b0;
      end
      m_pend <= npend; m_en <= nen; m_mode <= nmode; m_ins <= nins;
      m_q    <= s;
      m_irq  <= |cl;
    end
    m_s1 <= rst ? '0 : src;
    m_s2 <= rst ? '0 : m_s1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("irq_o", 32'(irq), 32'(m_irq));
      check("claim_id_o", 32'(cid), 32'(m_lowest(m_pend & m_en & ~m_ins)));
      check("ready", 32'(rsp.ready), 32'(req.valid));
      if (req.valid) begin
        check("error", 32'(rsp.error), 32'(!(req.addr inside {A_PEND, A_EN, A_MODE, A_CLAIM, A_INSVC})));
        if (!req.write) check("rdata", rsp.rdata, m_rdata(req.addr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic er);
    req.addr = a; req.write = w; req.wdata = d; req.wstrb = s; req.valid = 1'b1;
    @(negedge clk);
    rd = rsp.rdata;
    er = rsp.error;
    @(posedge clk);
    #1;
    req.valid = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic e;
    access(a, 1'b0, 32'h0, 4'hF, d, e);
    check(name, d, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rdv;
    logic e;
    access(a, 1'b1, d, 4'hF, rdv, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic e;
    req = '0;
    src = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    rd_chk("rst_pending", A_PEND, 0);
    rd_chk("rst_enable", A_EN, 0);
    rd_chk("rst_mode", A_MODE, 0);
    rd_chk("rst_claim", A_CLAIM, 0);
    rd_chk("rst_inservice", A_INSVC, 0);
    check("rst_irq", 32'(irq), 0);

    // Level source
    wr(A_EN, 32'h01);
    wr(A_MODE, 32'h00);
    src[0] = 1'b1;
    repeat (LAT - 1) tick();
    check("lvl_irq_early", 32'(irq), 0);
    tick();
    check("lvl_irq", 32'(irq), 1);
    rd_chk("lvl_claim", A_CLAIM, 1);
    tick();
    check("lvl_irq_drop", 32'(irq), 0);
    wr(A_CLAIM, 32'd1);
    tick();
    check("lvl_reassert", 32'(irq), 1);
    src[0] = 1'b0;
    repeat (LAT) tick();
    check("lvl_irq_low", 32'(irq), 0);

    // Edge sources, lowest ID first
    wr(A_EN, 32'h0C);
    wr(A_MODE, 32'h0C);
    src[3:2] = 2'b11;
    tick();
    src[3:2] = 2'b00;
    repeat (LAT) tick();
    rd_chk("edge_pending", A_PEND, 32'h0C);
    rd_chk("edge_claim3", A_CLAIM, 3);
    rd_chk("edge_pend_after3", A_PEND, 32'h08);
    rd_chk("edge_insvc3", A_INSVC, 32'h04);
    wr(A_CLAIM, 32'd3);
    rd_chk("edge_insvc_done", A_INSVC, 0);
    rd_chk("edge_claim4", A_CLAIM, 4);
    rd_chk("edge_pend_after4", A_PEND, 0);
    wr(A_CLAIM, 32'd4);

    // Edge set collides with W1C: set wins
    wr(A_EN, 32'h01);
    wr(A_MODE, 32'h01);
    src[0] = 1'b1;
    repeat (SYNC_D) tick();
    wr(A_PEND, 32'h01);
    rd_chk("collision_pend", A_PEND, 32'h01);
    rd_chk("collision_claim", A_CLAIM, 1);
    src[0] = 1'b0;

    // Illegal accesses
    access(32'h14, 1'b0, 32'h0, 4'hF, d, e);
    check("bad_addr_error", 32'(e), 1);
    check("bad_addr_rdata", d, 0);
    wr(A_CLAIM, 32'd0);
    wr(A_CLAIM, 32'd33);
    rd_chk("bad_complete_insvc", A_INSVC, 32'h01);
    wr(A_CLAIM, 32'd1);
    repeat (LAT) tick();
    rd_chk("empty_claim", A_CLAIM, 0);
    rd_chk("empty_insvc", A_INSVC, 0);
    rd_chk("empty_pend", A_PEND, 0);

    // Reset in the middle of service
    wr(A_MODE, 32'h00);
    wr(A_EN, 32'h02);
    src[1] = 1'b1;
    repeat (LAT + 1) tick();
    rd_chk("mid_claim2", A_CLAIM, 2);
    rd_chk("mid_insvc", A_INSVC, 32'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_irq", 32'(irq), 0);
    rd_chk("mid_rst_pend", A_PEND, 0);
    rd_chk("mid_rst_insvc", A_INSVC, 0);
    repeat (SYNC_D) tick();
    rd_chk("mid_repend", A_PEND, 32'h02);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) src[b] = ~src[b];
      rst       = ($urandom_range(0, 299) == 0);
      req.valid = 1'($urandom_range(0, 1));
      req.write = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: req.addr = A_PEND;
        1: req.addr = A_EN;
        2: req.addr = A_MODE;
        3: req.addr = A_CLAIM;
        4: req.addr = A_INSVC;
        5: req.addr = 32'h14;
        default: req.addr = $urandom();
      endcase
      req.wdata = ($urandom_range(0, 2) != 0) ? 32'($urandom_range(0, N + 2)) : $urandom();
      req.wstrb = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0;
    req.valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
